// File: rtl/cpu_pkg.sv
// Shared constants and FSM state encoding for the sequential add/subtract block.
package cpu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CHUNK = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_seq_add_chunk.sv
// CHUNK-bit combinational ripple adder slice; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most significant chunk.
module add_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  // Bit-serial ripple through the slice, LSB first.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = c_in;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[CHUNK];
    c_msb = carry[CHUNK-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: operands are latched on acceptance and summed
// CHUNK bits per clock, LSB chunk first, through a single shared add_chunk slice.
module addsub_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int          SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int unsigned N          = unsigned'(WIDTH / SAFE_CHUNK);
  localparam int          IDX_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("addsub_seq: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("addsub_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   next_acc;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK-1:0]   chunk_s;
  logic               chunk_cout;
  logic               chunk_cmsb;

  // Select the operand slice addressed by the current chunk index.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        chunk_a = a_reg[k*CHUNK +: CHUNK];
        chunk_b = b_reg[k*CHUNK +: CHUNK];
      end
    end
  end

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .c_in  (carry),
    .s     (chunk_s),
    .c_out (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // Merge this cycle's slice result into the partial sum, so the final chunk
  // can be published in the same edge that completes it.
  always_comb begin
    next_acc = acc;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        next_acc[k*CHUNK +: CHUNK] = chunk_s;
      end
    end
  end

  // Control FSM with registered handshakes; published result only changes on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            carry    <= c_in ^ sub;
            idx      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= next_acc;
          carry <= chunk_cout;
          if (idx == LAST) begin
            sum       <= next_acc;
            c_out     <= chunk_cout;
            ovf       <= chunk_cmsb ^ chunk_cout;
            zero      <= (next_acc == '0);
            neg       <= next_acc[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: three instances (8/2, 16/4, 8/8) driven
// in sequence and compared against an arithmetic reference model.
module tb_addsub_seq;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_d;
  logic [15:0] b_d;
  logic        sub_d;
  logic        cin_d;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  wire  [2:0]  irdy;
  wire  [2:0]  ovld;
  wire  [2:0]  co;
  wire  [2:0]  ov;
  wire  [2:0]  zr;
  wire  [2:0]  ng;
  wire  [7:0]  sum0;
  wire  [15:0] sum1;
  wire  [7:0]  sum2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  addsub_seq #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_d[7:0]), .b(b_d[7:0]), .sub(sub_d), .c_in(cin_d),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sum0),
    .c_out(co[0]), .ovf(ov[0]), .zero(zr[0]), .neg(ng[0])
  );

  addsub_seq #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_d), .b(b_d), .sub(sub_d), .c_in(cin_d),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sum1),
    .c_out(co[1]), .ovf(ov[1]), .zero(zr[1]), .neg(ng[1])
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a_d[7:0]), .b(b_d[7:0]), .sub(sub_d), .c_in(cin_d),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sum2),
    .c_out(co[2]), .ovf(ov[2]), .zero(zr[2]), .neg(ng[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result/carry and signed-range overflow.
  function automatic res_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, input logic cin);
    res_t   r;
    longint m;
    longint ai;
    longint bi;
    longint ci;
    longint u;
    longint sa;
    longint sb;
    longint sr;
    m  = longint'(1) << w;
    ai = longint'(a);
    bi = longint'(b);
    ci = cin ? 1 : 0;
    u  = sub ? (ai - bi - ci) : (ai + bi + ci);
    sa = (ai >= m / 2) ? ai - m : ai;
    sb = (bi >= m / 2) ? bi - m : bi;
    sr = sub ? (sa - sb - ci) : (sa + sb + ci);
    r.s  = 16'(u & (m - 1));
    r.co = sub ? (u >= 0) : (u >= m);
    r.ov = (sr < -(m / 2)) || (sr >= m / 2);
    r.z  = (r.s == 16'h0000);
    r.n  = r.s[w-1];
    return r;
  endfunction

  task automatic get_obs(input int w, output res_t r, output logic rdy, output logic vld);
    case (w)
      0:       r.s = {8'h00, sum0};
      1:       r.s = sum1;
      default: r.s = {8'h00, sum2};
    endcase
    r.co = co[w];
    r.ov = ov[w];
    r.z  = zr[w];
    r.n  = ng[w];
    rdy  = irdy[w];
    vld  = ovld[w];
  endtask

  task automatic drain(input int w, input string tag);
    res_t obs;
    logic rdy;
    logic vld;
    @(negedge clk);
    ordy[w] = 1'b1;
    get_obs(w, obs, rdy, vld);
    chk({tag, " in_ready_in_done"}, 16'(rdy), 16'd0);
    @(posedge clk);
    #1;
    ordy[w] = 1'b0;
    get_obs(w, obs, rdy, vld);
    chk({tag, " out_valid_after_take"}, 16'(vld), 16'd0);
    chk({tag, " in_ready_after_take"}, 16'(rdy), 16'd1);
  endtask

  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv, input bit do_drain, input string tag);
    res_t        exp;
    res_t        obs;
    logic        rdy;
    logic        vld;
    int          cyc;
    int          lat;
    int          width;
    logic [15:0] mask;
    mask  = (w == 1) ? 16'hFFFF : 16'h00FF;
    width = (w == 1) ? 16 : 8;
    lat   = (w == 2) ? 1 : 4;
    exp   = ref_model(width, av & mask, bv & mask, sv, cv);
    @(negedge clk);
    a_d     = av & mask;
    b_d     = bv & mask;
    sub_d   = sv;
    cin_d   = cv;
    iv[w]   = 1'b1;
    ordy[w] = 1'b0;
    get_obs(w, obs, rdy, vld);
    chk({tag, " in_ready_idle"}, 16'(rdy), 16'd1);
    @(posedge clk);
    #1;
    iv[w] = 1'b0;
    a_d   = 16'($urandom);
    b_d   = 16'($urandom);
    sub_d = ~sv;
    cin_d = ~cv;
    get_obs(w, obs, rdy, vld);
    chk({tag, " in_ready_busy"}, 16'(rdy), 16'd0);
    cyc = 0;
    while (!vld && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      get_obs(w, obs, rdy, vld);
    end
    chk({tag, " latency"}, 16'(cyc), 16'(lat));
    chk({tag, " sum"}, obs.s, exp.s);
    chk({tag, " c_out"}, 16'(obs.co), 16'(exp.co));
    chk({tag, " ovf"}, 16'(obs.ov), 16'(exp.ov));
    chk({tag, " zero"}, 16'(obs.z), 16'(exp.z));
    chk({tag, " neg"}, 16'(obs.n), 16'(exp.n));
    if (do_drain) drain(w, tag);
  endtask

  initial begin
    res_t held;
    res_t obs;
    logic rdy;
    logic vld;
    logic seen;

    rst_n = 1'b0;
    a_d   = '0;
    b_d   = '0;
    sub_d = 1'b0;
    cin_d = 1'b0;
    iv    = '0;
    ordy  = '0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      get_obs(w, obs, rdy, vld);
      chk("reset in_ready", 16'(rdy), 16'd1);
      chk("reset out_valid", 16'(vld), 16'd0);
      chk("reset sum", obs.s, 16'h0000);
      chk("reset flags", 16'({obs.co, obs.ov, obs.z, obs.n}), 16'h0);
    end
    rst_n = 1'b1;

    // Directed corner cases on the 8/2 instance.
    run_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1, "add_7f_01");
    run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b1, "add_ff_01");
    run_op(0, 16'h05, 16'h05, 1'b1, 1'b0, 1'b1, "sub_05_05");
    run_op(0, 16'h00, 16'h01, 1'b1, 1'b0, 1'b1, "sub_00_01");

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    a_d   = 16'h0012;
    b_d   = 16'h0034;
    sub_d = 1'b0;
    cin_d = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    get_obs(0, obs, rdy, vld);
    chk("rst_run out_valid", 16'(vld), 16'd0);
    chk("rst_run in_ready", 16'(rdy), 16'd1);
    chk("rst_run sum", obs.s, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ovld[0]) seen = 1'b1;
    end
    chk("rst_run no_result", 16'(seen), 16'd0);
    chk("rst_run idle_ready", 16'(irdy[0]), 16'd1);

    // Backpressure: result and flags hold while inputs churn and in_valid stays high.
    run_op(0, 16'h3C, 16'h5A, 1'b0, 1'b1, 1'b0, "bp");
    held = ref_model(8, 16'h3C, 16'h5A, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      iv[0] = 1'b1;
      a_d   = 16'($urandom);
      b_d   = 16'($urandom);
      sub_d = 1'($urandom_range(0, 1));
      cin_d = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      get_obs(0, obs, rdy, vld);
      chk("bp sum_hold", obs.s, held.s);
      chk("bp flags_hold", 16'({obs.co, obs.ov, obs.z, obs.n}), 16'({held.co, held.ov, held.z, held.n}));
      chk("bp in_ready", 16'(rdy), 16'd0);
      chk("bp out_valid", 16'(vld), 16'd1);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    drain(0, "bp");
    @(posedge clk);
    #1;
    get_obs(0, obs, rdy, vld);
    chk("bp no_second_accept", 16'(vld), 16'd0);
    chk("bp idle_sum_kept", obs.s, held.s);

    for (int i = 0; i < 20; i++) begin
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1, "rnd_w8c2");
    end

    run_op(1, 16'h1234, 16'h0FCC, 1'b0, 1'b1, 1'b1, "w16_add_1234");
    run_op(1, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1, "w16_sub_0_1_b");
    for (int i = 0; i < 8; i++) begin
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1, "rnd_w16c4");
    end

    run_op(2, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1, "w8c8_add_7f");
    run_op(2, 16'h80, 16'h01, 1'b1, 1'b0, 1'b1, "w8c8_sub_80");
    for (int i = 0; i < 8; i++) begin
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1, "rnd_w8c8");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 2, bits processed per clock cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-009 SHALL have port c_in  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have ports c_out, ovf, zero, neg  output  1 each  carry, signed overflow, result==0, result MSB.

Function
REQ-014 SHALL fail elaboration if WIDTH % CHUNK != 0 or CHUNK < 1; N = WIDTH/CHUNK.
REQ-015 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-016 SHALL, on in_valid && in_ready, latch a, (sub ? ~b : b) and initial carry = c_in ^ sub, clear chunk index, and go IDLE -> RUN.
REQ-017 SHALL in RUN process chunk i (bits i*CHUNK..i*CHUNK+CHUNK-1, LSB first) on the i-th edge after acceptance, propagating carry chunk to chunk.
REQ-018 SHALL go RUN -> DONE on the N-th edge after acceptance; out_valid high from that edge (latency N cycles; N=1 when CHUNK==WIDTH).
REQ-019 SHALL produce sum = a + b + c_in (mod 2^WIDTH) for add and a - b - c_in (mod 2^WIDTH) for subtract.
REQ-020 SHALL set c_out = carry out of bit WIDTH-1 (subtract: 1 = no borrow); ovf = carry into MSB XOR carry out of MSB; zero = (sum == 0); neg = sum[WIDTH-1].
REQ-021 SHALL hold sum and all flags stable while out_valid && !out_ready.
REQ-022 SHALL go DONE -> IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle re-accept).
REQ-023 SHALL ignore in_valid and input values while in RUN or DONE.
REQ-024 SHALL keep sum and flags at the last result in IDLE until the next result is published.

Reset
REQ-025 SHALL on rst_n low immediately enter IDLE: in_ready = 1, out_valid = 0, sum = 0, c_out = ovf = neg = 0, zero = 0, internal carry/index/operand registers = 0.
REQ-026 SHALL on reset asserted in RUN or DONE discard the operation; no out_valid after release until a new acceptance.

Structure
REQ-027 SHALL place the state encoding (IDLE/RUN/DONE) and default WIDTH/CHUNK constants in the shared package cpu_pkg.
REQ-028 SHALL instantiate one combinational sub-module add_chunk (CHUNK-bit ripple adder: a, b, c_in -> s, c_out, c_msb = carry into top bit), used for every chunk.

Verification
REQ-029 SHALL cover (WIDTH=8, CHUNK=2) add 0x7F+0x01, c_in=0 -> out_valid 4 cycles after accept, sum 0x80, c_out 0, ovf 1, neg 1, zero 0.
REQ-030 SHALL cover add 0xFF+0x01, c_in=0 -> sum 0x00, c_out 1, ovf 0, zero 1, neg 0.
REQ-031 SHALL cover subtract 0x05-0x05, c_in=0 -> sum 0x00, c_out 1, zero 1; subtract 0x00-0x01 -> sum 0xFF, c_out 0, neg 1, ovf 0.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 and changing a/b -> sum/flags constant, in_ready 0, no second acceptance; out_ready=1 -> IDLE, in_ready 1 next cycle.
REQ-033 SHALL cover reset mid-RUN: rst_n low 2 cycles after accept -> out_valid 0, in_ready 1, sum 0; no result emitted after release.
REQ-034 SHALL cover WIDTH=16, CHUNK=4 add 0x1234+0x0FCC, c_in=1 -> sum 0x2201, c_out 0, ovf 0, out_valid 4 cycles after accept; and WIDTH=8, CHUNK=8 -> latency 1.
